// File: rtl/video_timing.sv
// Pong sync/blanking generator: cascaded pixel/line counters with registered
// decode of the next count, so every output lines up with HCNT/VCNT.
`timescale 1ns/1ps
module video_timing #(
  parameter int H_TOTAL      = 455,
  parameter int H_BLANK_END  = 80,
  parameter int H_SYNC_START = 32,
  parameter int H_SYNC_END   = 64,
  parameter int V_TOTAL      = 262,
  parameter int V_BLANK_END  = 16,
  parameter int V_SYNC_START = 4,
  parameter int V_SYNC_END   = 8
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       CE,
  output logic [8:0] HCNT,
  output logic [8:0] VCNT,
  output logic       HSYNC_N,
  output logic       VSYNC_N,
  output logic       HBLANK_N,
  output logic       VBLANK_N,
  output logic       HRESET,
  output logic       VRESET
);

  localparam logic [8:0] LP_H_MAX   = 9'(H_TOTAL - 1);
  localparam logic [8:0] LP_H_BEND  = 9'(H_BLANK_END);
  localparam logic [8:0] LP_H_SSTRT = 9'(H_SYNC_START);
  localparam logic [8:0] LP_H_SEND  = 9'(H_SYNC_END);
  localparam logic [8:0] LP_V_MAX   = 9'(V_TOTAL - 1);
  localparam logic [8:0] LP_V_BEND  = 9'(V_BLANK_END);
  localparam logic [8:0] LP_V_SSTRT = 9'(V_SYNC_START);
  localparam logic [8:0] LP_V_SEND  = 9'(V_SYNC_END);

  function automatic logic in_window(input logic [8:0] cnt,
                                     input logic [8:0] lo,
                                     input logic [8:0] hi);
    return (cnt >= lo) && (cnt < hi);
  endfunction

  logic [8:0] r_hcnt_p1;
  logic [8:0] r_vcnt_p1;
  logic       r_hsync_n_p1;
  logic       r_vsync_n_p1;
  logic       r_hblank_n_p1;
  logic       r_vblank_n_p1;
  logic       r_hreset_p1;
  logic       r_vreset_p1;

  logic       w_hwrap_p0;
  logic [8:0] w_hcnt_p0;
  logic [8:0] w_vcnt_p0;
  logic       w_hlast_p0;

  // Stage p0: next-count values, decoded before they are registered
  assign w_hwrap_p0 = (r_hcnt_p1 == LP_H_MAX);
  assign w_hcnt_p0  = w_hwrap_p0 ? 9'd0 : r_hcnt_p1 + 9'd1;
  assign w_vcnt_p0  = !w_hwrap_p0            ? r_vcnt_p1 :
                      (r_vcnt_p1 == LP_V_MAX) ? 9'd0      : r_vcnt_p1 + 9'd1;
  assign w_hlast_p0 = (w_hcnt_p0 == LP_H_MAX);

  // Stage p1: registered counts and decode; everything holds while CE is low
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_hcnt_p1     <= 9'd0;
      r_vcnt_p1     <= 9'd0;
      r_hsync_n_p1  <= 1'b1;
      r_vsync_n_p1  <= 1'b1;
      r_hblank_n_p1 <= 1'b0;
      r_vblank_n_p1 <= 1'b0;
      r_hreset_p1   <= 1'b0;
      r_vreset_p1   <= 1'b0;
    end else if (CE) begin
      r_hcnt_p1     <= w_hcnt_p0;
      r_vcnt_p1     <= w_vcnt_p0;
      r_hsync_n_p1  <= !in_window(w_hcnt_p0, LP_H_SSTRT, LP_H_SEND);
      r_vsync_n_p1  <= !in_window(w_vcnt_p0, LP_V_SSTRT, LP_V_SEND);
      r_hblank_n_p1 <= (w_hcnt_p0 >= LP_H_BEND);
      r_vblank_n_p1 <= (w_vcnt_p0 >= LP_V_BEND);
      r_hreset_p1   <= w_hlast_p0;
      r_vreset_p1   <= w_hlast_p0 && (w_vcnt_p0 == LP_V_MAX);
    end
  end

  assign HCNT     = r_hcnt_p1;
  assign VCNT     = r_vcnt_p1;
  assign HSYNC_N  = r_hsync_n_p1;
  assign VSYNC_N  = r_vsync_n_p1;
  assign HBLANK_N = r_hblank_n_p1;
  assign VBLANK_N = r_vblank_n_p1;
  assign HRESET   = r_hreset_p1;
  assign VRESET   = r_vreset_p1;

endmodule

// File: tb/tb_video_timing.sv
// Scoreboard bench for video_timing: default-timing instance plus a tiny
// parameter-override instance that wraps many frames within a short run.
`timescale 1ns/1ps
module tb_video_timing;

  typedef struct packed {
    logic [8:0] h;
    logic [8:0] v;
    logic hs, vs, hb, vb, hr, vr;
  } exp_t;

  localparam exp_t RST_E = '{h: 9'd0, v: 9'd0, hs: 1'b1, vs: 1'b1,
                             hb: 1'b0, vb: 1'b0, hr: 1'b0, vr: 1'b0};

  logic CLK = 1'b0;
  logic RESET_N;
  logic CE;
  always #5 CLK = ~CLK;

  logic [8:0] d_hcnt, d_vcnt, s_hcnt, s_vcnt;
  logic d_hs, d_vs, d_hb, d_vb, d_hr, d_vr;
  logic s_hs, s_vs, s_hb, s_vb, s_hr, s_vr;

  video_timing u_def (
    .CLK(CLK), .RESET_N(RESET_N), .CE(CE),
    .HCNT(d_hcnt), .VCNT(d_vcnt),
    .HSYNC_N(d_hs), .VSYNC_N(d_vs), .HBLANK_N(d_hb), .VBLANK_N(d_vb),
    .HRESET(d_hr), .VRESET(d_vr)
  );

  video_timing #(
    .H_TOTAL(10), .H_BLANK_END(5), .H_SYNC_START(2), .H_SYNC_END(4),
    .V_TOTAL(4),  .V_BLANK_END(2), .V_SYNC_START(1), .V_SYNC_END(2)
  ) u_sml (
    .CLK(CLK), .RESET_N(RESET_N), .CE(CE),
    .HCNT(s_hcnt), .VCNT(s_vcnt),
    .HSYNC_N(s_hs), .VSYNC_N(s_vs), .HBLANK_N(s_hb), .VBLANK_N(s_vb),
    .HRESET(s_hr), .VRESET(s_vr)
  );

  exp_t q_def[$];
  exp_t q_sml[$];
  int checks = 0;
  int errors = 0;
  int mh_d, mv_d, mh_s, mv_s, n_ce;
  logic mon_ce, mon_rn;

  function automatic exp_t mk(input int h, input int v,
                              input bit hs, input bit vs, input bit hb,
                              input bit vb, input bit hr, input bit vr);
    exp_t e;
    e.h = 9'(h); e.v = 9'(v);
    e.hs = hs; e.vs = vs; e.hb = hb; e.vb = vb; e.hr = hr; e.vr = vr;
    return e;
  endfunction

  function automatic exp_t ref_out(input int h, input int v,
                                   input int ht, input int hss, input int hse, input int hbe,
                                   input int vt, input int vss, input int vse, input int vbe);
    return mk(h, v, !(h >= hss && h < hse), !(v >= vss && v < vse),
              h >= hbe, v >= vbe, h == ht - 1, (h == ht - 1) && (v == vt - 1));
  endfunction

  function automatic exp_t ref_def(input int h, input int v);
    return ref_out(h, v, 455, 32, 64, 80, 262, 4, 8, 16);
  endfunction

  function automatic exp_t ref_sml(input int h, input int v);
    return ref_out(h, v, 10, 2, 4, 5, 4, 1, 2, 2);
  endfunction

  // Hand-computed vectors, indexed by CE edges since reset release
  function automatic bit cp_def(input int n, output exp_t e);
    cp_def = 1'b1;
    case (n)
      1:       e = mk(1,   0, 1, 1, 0, 0, 0, 0);
      31:      e = mk(31,  0, 1, 1, 0, 0, 0, 0);
      32:      e = mk(32,  0, 0, 1, 0, 0, 0, 0);
      63:      e = mk(63,  0, 0, 1, 0, 0, 0, 0);
      64:      e = mk(64,  0, 1, 1, 0, 0, 0, 0);
      79:      e = mk(79,  0, 1, 1, 0, 0, 0, 0);
      80:      e = mk(80,  0, 1, 1, 1, 0, 0, 0);
      454:     e = mk(454, 0, 1, 1, 1, 0, 1, 0);
      455:     e = mk(0,   1, 1, 1, 0, 0, 0, 0);
      1819:    e = mk(454, 3, 1, 1, 1, 0, 1, 0);
      1820:    e = mk(0,   4, 1, 0, 0, 0, 0, 0);
      1852:    e = mk(32,  4, 0, 0, 0, 0, 0, 0);
      2274:    e = mk(454, 4, 1, 0, 1, 0, 1, 0);
      2275:    e = mk(0,   5, 1, 0, 0, 0, 0, 0);
      default: begin e = RST_E; cp_def = 1'b0; end
    endcase
  endfunction

  function automatic bit cp_sml(input int n, output exp_t e);
    cp_sml = 1'b1;
    case (n)
      12:      e = mk(2, 1, 0, 0, 0, 0, 0, 0);
      39:      e = mk(9, 3, 1, 1, 1, 1, 1, 1);
      40:      e = mk(0, 0, 1, 1, 0, 0, 0, 0);
      default: begin e = RST_E; cp_sml = 1'b0; end
    endcase
  endfunction

  function automatic exp_t act_def();
    return mk(int'(d_hcnt), int'(d_vcnt), d_hs, d_vs, d_hb, d_vb, d_hr, d_vr);
  endfunction

  function automatic exp_t act_sml();
    return mk(int'(s_hcnt), int'(s_vcnt), s_hs, s_vs, s_hb, s_vb, s_hr, s_vr);
  endfunction

  task automatic check(input string name, input exp_t act, input exp_t req);
    checks++;
    if (act !== req) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b hr=%b vr=%b, expected h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b hr=%b vr=%b (t=%0t)",
                 name, act.h, act.v, act.hs, act.vs, act.hb, act.vb, act.hr, act.vr,
                 req.h, req.v, req.hs, req.vs, req.hb, req.vb, req.hr, req.vr, $time);
    end
  endtask

  task automatic model_reset();
    mh_d = 0; mv_d = 0; mh_s = 0; mv_s = 0; n_ce = 0;
  endtask

  task automatic advance(inout int h, inout int v, input int ht, input int vt);
    if (h == ht - 1) begin
      h = 0;
      v = (v == vt - 1) ? 0 : v + 1;
    end else begin
      h = h + 1;
    end
  endtask

  // Driver: one clock per call; on a CE edge, push the expected outputs
  task automatic step(input logic ce);
    exp_t e;
    @(negedge CLK);
    CE = ce;
    @(posedge CLK);
    if (ce && RESET_N) begin
      n_ce++;
      advance(mh_d, mv_d, 455, 262);
      advance(mh_s, mv_s, 10, 4);
      if (!cp_def(n_ce, e)) e = ref_def(mh_d, mv_d);
      q_def.push_back(e);
      if (!cp_sml(n_ce, e)) e = ref_sml(mh_s, mv_s);
      q_sml.push_back(e);
    end
  endtask

  // Monitor: CE edges pop the scoreboard, idle edges must hold state
  always @(posedge CLK) begin
    mon_ce = CE;
    mon_rn = RESET_N;
    #1;
    if (mon_rn && RESET_N) begin
      if (mon_ce) begin
        if (q_def.size() == 0 || q_sml.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_empty: got def=%0d sml=%0d entries, expected at least 1 each",
                   q_def.size(), q_sml.size());
        end else begin
          check("def_ce_edge", act_def(), q_def.pop_front());
          check("sml_ce_edge", act_sml(), q_sml.pop_front());
        end
      end else begin
        check("def_hold", act_def(), ref_def(mh_d, mv_d));
        check("sml_hold", act_sml(), ref_sml(mh_s, mv_s));
      end
    end
  end

  initial begin
    RESET_N = 1'b0;
    CE      = 1'b0;
    model_reset();

    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      CE = ~CE;
      @(posedge CLK);
      #1;
      check("def_reset_hold", act_def(), RST_E);
      check("sml_reset_hold", act_sml(), RST_E);
    end

    @(negedge CLK);
    CE = 1'b0;
    RESET_N = 1'b1;

    repeat (1860) step(1'b1);

    for (int i = 0; i < 455; i++) begin
      step(1'b1);
      step(1'b0);
      step(1'b0);
      step(1'b0);
    end

    // Asynchronous reset between clock edges, partway into a frame
    @(negedge CLK);
    #2;
    RESET_N = 1'b0;
    #1;
    check("def_async_reset", act_def(), RST_E);
    check("sml_async_reset", act_sml(), RST_E);
    model_reset();
    step(1'b1);
    step(1'b1);
    #1;
    check("def_reset_ce_high", act_def(), RST_E);
    check("sml_reset_ce_high", act_sml(), RST_E);
    @(negedge CLK);
    CE = 1'b0;
    RESET_N = 1'b1;
    repeat (100) step(1'b1);

    @(negedge CLK);
    checks++;
    if (q_def.size() != 0 || q_sml.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got def=%0d sml=%0d entries left, expected 0",
               q_def.size(), q_sml.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
